bus_slave_sel: RTL and testbench

//   Parametrised, registered bus address decoder with access tracking. Decodes slave index

---
 rtl/bus_slave_sel_pkg.sv | 26 ++
 rtl/bus_slave_sel_tmo.sv | 29 ++
 rtl/bus_slave_sel.sv | 112 +++++++++++
 tb/tb_bus_slave_sel.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_slave_sel_pkg.sv
// Shared definitions for the bus slave decoder: FSM encodings, active-low levels,
// default index field placement and slave index constants.
package bus_slave_sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERR    = 2'd2
    } bus_state_e;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int unsigned DEF_IDX_W   = 3;
    localparam int unsigned DEF_IDX_LSB = 27;

    localparam logic [DEF_IDX_W-1:0] BUS_SLAVE_0 = 3'd0;
    localparam logic [DEF_IDX_W-1:0] BUS_SLAVE_1 = 3'd1;
    localparam logic [DEF_IDX_W-1:0] BUS_SLAVE_2 = 3'd2;
    localparam logic [DEF_IDX_W-1:0] BUS_SLAVE_3 = 3'd3;
    localparam logic [DEF_IDX_W-1:0] BUS_SLAVE_4 = 3'd4;
    localparam logic [DEF_IDX_W-1:0] BUS_SLAVE_5 = 3'd5;
    localparam logic [DEF_IDX_W-1:0] BUS_SLAVE_6 = 3'd6;
    localparam logic [DEF_IDX_W-1:0] BUS_SLAVE_7 = 3'd7;

endpackage

// File: rtl/bus_slave_sel_tmo.sv
// Access timeout counter: cleared outside an access, saturating increment while
// waiting, expire_c flags the last permitted waiting cycle.
module bus_slave_sel_tmo #(
    parameter int unsigned TMO_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset_,
    input  logic clr,
    input  logic inc,
    output logic expire_c
);

    localparam logic [TMO_W-1:0] CNT_MAX  = {TMO_W{1'b1}};
    localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_ || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    assign expire_c = inc && (cnt == CNT_LAST);

endmodule

// File: rtl/bus_slave_sel.sv
// Registered bus address decoder: one-hot active-low chip selects, ready return and
// bus error on unmapped index. Define BUS_SLAVE_SEL_TIMEOUT_EN to add an access timeout.
module bus_slave_sel
    import bus_slave_sel_pkg::*;
#(
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned NUM_SLAVES  = 8,
    parameter int unsigned IDX_W       = DEF_IDX_W,
    parameter int unsigned IDX_LSB     = DEF_IDX_LSB,
    parameter int unsigned TMO_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  m_as_,
    input  logic [ADDR_W-1:0]     m_addr,
    input  logic [NUM_SLAVES-1:0] s_rdy_,
    output logic [NUM_SLAVES-1:0] s_cs_,
    output logic [IDX_W-1:0]      s_sel,
    output logic                  m_rdy_,
    output logic                  m_err
);

    bus_state_e            state, state_n;
    logic [NUM_SLAVES-1:0] cs_n, cs_dec;
    logic [IDX_W-1:0]      sel_n, idx;
    logic                  mapped, sel_rdy, tmo_expire_c;
    logic                  unused_addr;

    assign idx         = m_addr[IDX_LSB +: IDX_W];
    assign unused_addr = ^m_addr;
    assign mapped      = {1'b0, idx} < (IDX_W+1)'(NUM_SLAVES);
    assign sel_rdy     = (state == ST_ACCESS) && (s_rdy_[s_sel] == ENABLE_);

`ifdef BUS_SLAVE_SEL_TIMEOUT_EN
    bus_slave_sel_tmo #(
        .TMO_W       (TMO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk      (clk),
        .reset_   (reset_),
        .clr      (state != ST_ACCESS),
        .inc      ((state == ST_ACCESS) && !sel_rdy),
        .expire_c (tmo_expire_c)
    );
`else
    logic [TMO_W-1:0] unused_tmo;
    assign unused_tmo   = TMO_W'(TIMEOUT_CYC);
    assign tmo_expire_c = 1'b0;
`endif

    always_comb begin
        cs_dec = {NUM_SLAVES{DISABLE_}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            cs_dec[i] = (IDX_W'(i) == idx) ? ENABLE_ : DISABLE_;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state <= ST_IDLE;
            s_cs_ <= {NUM_SLAVES{DISABLE_}};
            s_sel <= '0;
        end else begin
            state <= state_n;
            s_cs_ <= cs_n;
            s_sel <= sel_n;
        end
    end

    // Ready beats both abort and timeout in the same cycle.
    always_comb begin
        state_n = state;
        cs_n    = s_cs_;
        sel_n   = s_sel;
        unique case (state)
            ST_IDLE: begin
                if (m_as_ == ENABLE_) begin
                    if (mapped) begin
                        state_n = ST_ACCESS;
                        sel_n   = idx;
                        cs_n    = cs_dec;
                    end else begin
                        state_n = ST_ERR;
                    end
                end
            end
            ST_ACCESS: begin
                if (sel_rdy || (m_as_ == DISABLE_)) begin
                    state_n = ST_IDLE;
                    cs_n    = {NUM_SLAVES{DISABLE_}};
                end else if (tmo_expire_c) begin
                    state_n = ST_ERR;
                    cs_n    = {NUM_SLAVES{DISABLE_}};
                end
            end
            ST_ERR: begin
                state_n = ST_IDLE;
                cs_n    = {NUM_SLAVES{DISABLE_}};
            end
            default: begin
                state_n = ST_IDLE;
                cs_n    = {NUM_SLAVES{DISABLE_}};
            end
        endcase
    end

    // Error is a decode of the state register; ready follows the selected slave live.
    assign m_err  = (state == ST_ERR);
    assign m_rdy_ = (state == ST_ERR) ? ENABLE_ : (sel_rdy ? ENABLE_ : DISABLE_);

endmodule

// File: tb/tb_bus_slave_sel.sv
// Directed bench for bus_slave_sel: an 8-slave and a 6-slave instance share stimulus.
module tb_bus_slave_sel;
    import bus_slave_sel_pkg::*;

    logic       clk = 1'b0;
    logic       reset_;
    logic       m_as_;
    logic [29:0] m_addr;
    logic [7:0] s_rdy_;

    logic [7:0] cs8;
    logic [2:0] sel8;
    logic       rdy8, err8;
    logic [5:0] cs6;
    logic [2:0] sel6;
    logic       rdy6, err6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_slave_sel #(.NUM_SLAVES(8), .TIMEOUT_CYC(4)) u_dut8 (
        .clk(clk), .reset_(reset_), .m_as_(m_as_), .m_addr(m_addr), .s_rdy_(s_rdy_),
        .s_cs_(cs8), .s_sel(sel8), .m_rdy_(rdy8), .m_err(err8)
    );

    bus_slave_sel #(.NUM_SLAVES(6), .TIMEOUT_CYC(4)) u_dut6 (
        .clk(clk), .reset_(reset_), .m_as_(m_as_), .m_addr(m_addr), .s_rdy_(s_rdy_[5:0]),
        .s_cs_(cs6), .s_sel(sel6), .m_rdy_(rdy6), .m_err(err6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [2:0] idx);
        m_addr = {idx, 27'h5a5_a5a5};
        m_as_  = 1'b0;
    endtask

    initial begin
        logic seen_err;
        reset_ = 1'b1;
        m_as_  = 1'b1;
        m_addr = '0;
        s_rdy_ = 8'hFF;

        // Reset while strobe is asserted
        reset_ = 1'b0;
        start(BUS_SLAVE_5);
        tick();
        chk("rst_cs", cs8, 8'hFF);
        chk("rst_rdy", {7'd0, rdy8}, 8'd1);
        chk("rst_err", {7'd0, err8}, 8'd0);
        chk("rst_sel", {5'd0, sel8}, 8'd0);
        chk("rst_cs6", {2'd0, cs6}, 8'h3F);
        reset_ = 1'b1;
        m_as_  = 1'b1;
        tick();

        // Decode slave 5, ready two cycles later
        start(BUS_SLAVE_5);
        tick();
        chk("dec_cs", cs8, 8'hDF);
        chk("dec_sel", {5'd0, sel8}, 8'd5);
        chk("dec_rdy_wait", {7'd0, rdy8}, 8'd1);
        tick();
        s_rdy_ = 8'hDF;
        #1;
        chk("dec_rdy", {7'd0, rdy8}, 8'd0);
        chk("dec_err", {7'd0, err8}, 8'd0);
        m_as_ = 1'b1;
        tick();
        s_rdy_ = 8'hFF;
        #1;
        chk("dec_release", cs8, 8'hFF);
        chk("dec_idle_rdy", {7'd0, rdy8}, 8'd1);

        // Unmapped index on the 6-slave instance; 8-slave instance maps it
        start(BUS_SLAVE_7);
        tick();
        chk("unm_cs6", {2'd0, cs6}, 8'h3F);
        chk("unm_rdy6", {7'd0, rdy6}, 8'd0);
        chk("unm_err6", {7'd0, err6}, 8'd1);
        chk("map7_cs8", cs8, 8'h7F);
        m_as_ = 1'b1;
        tick();
        chk("unm_err6_clr", {7'd0, err6}, 8'd0);
        chk("unm_rdy6_clr", {7'd0, rdy6}, 8'd1);
        chk("abort7_cs8", cs8, 8'hFF);
        chk("abort7_err8", {7'd0, err8}, 8'd0);

        // First unmapped index boundary
        start(BUS_SLAVE_6);
        tick();
        chk("unm6_err6", {7'd0, err6}, 8'd1);
        chk("map6_cs8", cs8, 8'hBF);
        m_as_ = 1'b1;
        tick();
        chk("unm6_err6_clr", {7'd0, err6}, 8'd0);

        // Non-selected ready ignored, then abort
        start(BUS_SLAVE_1);
        tick();
        chk("ign_cs", cs8, 8'hFD);
        s_rdy_ = 8'hF7;
        #1;
        chk("ign_rdy", {7'd0, rdy8}, 8'd1);
        tick();
        chk("ign_cs_hold", cs8, 8'hFD);
        m_as_ = 1'b1;
        tick();
        chk("abort_cs", cs8, 8'hFF);
        chk("abort_rdy", {7'd0, rdy8}, 8'd1);
        chk("abort_err", {7'd0, err8}, 8'd0);
        s_rdy_ = 8'hFF;

        // Held strobe re-decodes after one idle cycle; address changes ignored in access
        start(BUS_SLAVE_2);
        tick();
        chk("held_cs", cs8, 8'hFB);
        m_addr = {BUS_SLAVE_3, 27'h0};
        s_rdy_ = 8'hFB;
        tick();
        s_rdy_ = 8'hFF;
        #1;
        chk("held_idle", cs8, 8'hFF);
        tick();
        chk("held_redec", cs8, 8'hF7);
        chk("held_sel", {5'd0, sel8}, 8'd3);
        m_as_ = 1'b1;
        tick();

        // Reset in the middle of an access
        start(BUS_SLAVE_4);
        tick();
        chk("mid_cs", cs8, 8'hEF);
        reset_ = 1'b0;
        tick();
        chk("mid_rst_cs", cs8, 8'hFF);
        chk("mid_rst_err", {7'd0, err8}, 8'd0);
        chk("mid_rst_sel", {5'd0, sel8}, 8'd0);
        reset_ = 1'b1;
        m_as_  = 1'b1;
        tick();

`ifdef BUS_SLAVE_SEL_TIMEOUT_EN
        // Timeout after four waiting cycles
        start(BUS_SLAVE_2);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("tmo_wait_cs", cs8, 8'hFB);
            chk("tmo_wait_err", {7'd0, err8}, 8'd0);
            tick();
        end
        chk("tmo_err", {7'd0, err8}, 8'd1);
        chk("tmo_rdy", {7'd0, rdy8}, 8'd0);
        chk("tmo_cs", cs8, 8'hFF);
        m_as_ = 1'b1;
        tick();
        chk("tmo_err_clr", {7'd0, err8}, 8'd0);

        // Ready on the last permitted cycle wins
        start(BUS_SLAVE_2);
        tick();
        tick();
        tick();
        tick();
        s_rdy_ = 8'hFB;
        #1;
        chk("tmo_last_rdy", {7'd0, rdy8}, 8'd0);
        chk("tmo_last_err", {7'd0, err8}, 8'd0);
        m_as_ = 1'b1;
        tick();
        s_rdy_ = 8'hFF;
        #1;
        chk("tmo_last_cs", cs8, 8'hFF);
        chk("tmo_last_err2", {7'd0, err8}, 8'd0);
`else
        // Without timeout an access waits indefinitely
        seen_err = 1'b0;
        start(BUS_SLAVE_2);
        repeat (1000) begin
            tick();
            if (err8 !== 1'b0) seen_err = 1'b1;
        end
        chk("long_no_err", {7'd0, seen_err}, 8'd0);
        chk("long_cs", cs8, 8'hFB);
        m_as_ = 1'b1;
        tick();
        chk("long_abort_cs", cs8, 8'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
